// File: rtl/alu_seq_unit.sv
// Handshaked RV32I ALU responder; shifts are serial unless
// ALU_SEQ_BARREL_SHIFT_EN is defined, which computes them in one step.
module alu_seq_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [5:0]            i_alu_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_c
);

   localparam logic [5:0] OP_ALU_NOP  = 6'd0;
   localparam logic [5:0] OP_ALU_ADD  = 6'd1;
   localparam logic [5:0] OP_ALU_SUB  = 6'd2;
   localparam logic [5:0] OP_ALU_AND  = 6'd3;
   localparam logic [5:0] OP_ALU_OR   = 6'd4;
   localparam logic [5:0] OP_ALU_XOR  = 6'd5;
   localparam logic [5:0] OP_ALU_SLT  = 6'd6;
   localparam logic [5:0] OP_ALU_SLTU = 6'd7;
   localparam logic [5:0] OP_ALU_SLL  = 6'd8;
   localparam logic [5:0] OP_ALU_SRL  = 6'd9;
   localparam logic [5:0] OP_ALU_SRA  = 6'd10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      S_SHIFT = 2'd1,
`endif
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;

   function automatic logic [DATA_WIDTH-1:0] alu_fn(
      input logic [5:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      logic [4:0] sh;
      sh = b[4:0];
`endif
      r = '0;
      case (op)
         OP_ALU_ADD:  r = a + b;
         OP_ALU_SUB:  r = a - b;
         OP_ALU_AND:  r = a & b;
         OP_ALU_OR:   r = a | b;
         OP_ALU_XOR:  r = a ^ b;
         OP_ALU_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_ALU_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, a < b};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
         OP_ALU_SLL:  r = a << sh;
         OP_ALU_SRL:  r = a >> sh;
         OP_ALU_SRA:  r = $unsigned($signed(a) >>> sh);
`endif
         default:     r = '0;
      endcase
      return r;
   endfunction

`ifndef ALU_SEQ_BARREL_SHIFT_EN
   logic [4:0] cnt_q, cnt_d;
   logic [5:0] op_q, op_d;
   logic       fill_q, fill_d;
   logic       is_shift;

   assign is_shift = (i_alu_op == OP_ALU_SLL) ||
                     (i_alu_op == OP_ALU_SRL) ||
                     (i_alu_op == OP_ALU_SRA);
`endif

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      cnt_d   = cnt_q;
      op_d    = op_q;
      fill_d  = fill_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
               res_d   = alu_fn(i_alu_op, i_a, i_b);
               state_d = S_DONE;
`else
               if (is_shift) begin
                  res_d  = i_a;
                  op_d   = i_alu_op;
                  fill_d = i_a[DATA_WIDTH-1];
                  if (i_b[4:0] == 5'd0) begin
                     state_d = S_DONE;
                  end else begin
                     cnt_d   = i_b[4:0];
                     state_d = S_SHIFT;
                  end
               end else begin
                  res_d   = alu_fn(i_alu_op, i_a, i_b);
                  state_d = S_DONE;
               end
`endif
            end
         end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         S_SHIFT: begin
            case (op_q)
               OP_ALU_SLL: res_d = {res_q[DATA_WIDTH-2:0], 1'b0};
               OP_ALU_SRA: res_d = {fill_q, res_q[DATA_WIDTH-1:1]};
               default:    res_d = {1'b0, res_q[DATA_WIDTH-1:1]};
            endcase
            cnt_d = cnt_q - 5'd1;
            // count still holds the pre-decrement value on the last shift
            if (cnt_q == 5'd1) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         res_q   <= '0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         cnt_q   <= 5'd0;
         op_q    <= OP_ALU_NOP;
         fill_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
`endif
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_c     = res_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: results, latency, backpressure
// and asynchronous reset during a serial shift.
module tb_alu_seq_unit;

   localparam logic [5:0] NOP  = 6'd0;
   localparam logic [5:0] ADD  = 6'd1;
   localparam logic [5:0] SUB  = 6'd2;
   localparam logic [5:0] AND_ = 6'd3;
   localparam logic [5:0] OR_  = 6'd4;
   localparam logic [5:0] XOR_ = 6'd5;
   localparam logic [5:0] SLT  = 6'd6;
   localparam logic [5:0] SLTU = 6'd7;
   localparam logic [5:0] SLL  = 6'd8;
   localparam logic [5:0] SRL  = 6'd9;
   localparam logic [5:0] SRA  = 6'd10;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [5:0]  i_alu_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq_unit #(.DATA_WIDTH(32)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_alu_op (i_alu_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_c      (o_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request with i_ready already high, measure latency in
   // edges counted from the accept edge, then confirm return to IDLE.
   task automatic run_op(input string tag, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_c, input int exp_lat);
      int lat;
      @(negedge clk);
      chk({tag, "_ready"}, {31'b0, o_ready}, 32'h1);
      i_valid  = 1'b1;
      i_alu_op = op;
      i_a      = a;
      i_b      = b;
      @(posedge clk);
      #1;
      i_valid  = 1'b0;
      i_alu_op = 6'h3F;
      i_a      = $urandom;
      i_b      = $urandom;
      lat = 1;
      while (!o_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_valid"}, {31'b0, o_valid}, 32'h1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_c"}, o_c, exp_c);
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, {30'b0, o_valid, o_ready}, 32'h1);
   endtask

   initial begin
      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      i_alu_op = NOP;
      i_a      = '0;
      i_b      = '0;
      #12;
      chk("rst_ready", {31'b0, o_ready}, 32'h1);
      chk("rst_valid", {31'b0, o_valid}, 32'h0);
      chk("rst_c", o_c, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add", ADD, 32'd5, 32'd3, 32'h8, 1);
      run_op("sub", SUB, 32'hA, 32'd3, 32'h7, 1);
      run_op("and", AND_, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1);
      run_op("or", OR_, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1);
      run_op("xor", XOR_, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1);
      run_op("slt", SLT, 32'hFFFFFFFE, 32'h1, 32'h1, 1);
      run_op("slt_f", SLT, 32'h1, 32'hFFFFFFFE, 32'h0, 1);
      run_op("sltu", SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 1);
      run_op("sltu_f", SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
      run_op("sub_wrap", SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1);
      run_op("sll", SLL, 32'h1, 32'd4, 32'h10, BARREL ? 1 : 5);
      run_op("sra", SRA, 32'hFFFFFFF0, 32'd2, 32'hFFFFFFFC, BARREL ? 1 : 3);
      run_op("srl", SRL, 32'h10, 32'd2, 32'h4, BARREL ? 1 : 3);
      run_op("srl_hi", SRL, 32'h80000000, 32'd4, 32'h08000000,
             BARREL ? 1 : 5);
      run_op("sh_b20", SLL, 32'h12345678, 32'h20, 32'h12345678, 1);
      run_op("sra31", SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF,
             BARREL ? 1 : 32);
      run_op("undef", 6'h3F, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
      run_op("nop", NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1);

      // Backpressure: response must hold while new requests are ignored.
      i_ready = 1'b0;
      @(negedge clk);
      i_valid  = 1'b1;
      i_alu_op = ADD;
      i_a      = 32'd100;
      i_b      = 32'd23;
      @(posedge clk);
      #1;
      i_alu_op = SUB;
      i_a      = 32'd1;
      i_b      = 32'd1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp_state", {30'b0, o_valid, o_ready}, 32'h2);
         chk("bp_c", o_c, 32'd123);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {30'b0, o_valid, o_ready}, 32'h1);
      chk("bp_c_after", o_c, 32'd123);

      // Asynchronous reset while a long shift is in flight.
      @(negedge clk);
      i_valid  = 1'b1;
      i_alu_op = SLL;
      i_a      = 32'h1;
      i_b      = 32'd20;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      if (!BARREL) chk("mid_shift", {30'b0, o_valid, o_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_async", {30'b0, o_valid, o_ready}, 32'h1);
      chk("rst_async_c", o_c, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", ADD, 32'd5, 32'd3, 32'h8, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
